memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline stage directly downstream of execute. Consumes the ALU result (effective address or arithmetic result), store data and funct3, and performs aligned byte/half/word accesses on a single-outstanding data-memory bus. It produces sign- or zero-extended load data, or passes non-memory results through, as writeback data for the writeback stage. It uses the same prev_done/stall_prev and done_next/next_stall handshake as every other pipeline stage.

## Interface
- ADDR_WIDTH, 32, byte address width (localparam)
- DATA_WIDTH, 32, data/bus width (localparam)
- REGISTER_INDEXING_WIDTH, 5, register index width (localparam)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- prev_done  in  1  upstream holds a valid instruction
- stall_prev  out  1  upstream must hold its instruction
- next_stall  in  1  downstream cannot accept
- done_next  out  1  this stage holds a completed instruction
- program_count_in / program_count_out  in/out  32  instruction PC, passed through
- load_in, store_in  in  1 each  memory operation class
- funct_3_in  in  3  access size/signedness
- result_data_in, result_data_valid_in  in  32, 1  ALU result / effective address
- memory_store_data_in, memory_store_data_valid_in  in  32, 1  store data (rs2)
- write_register_in / write_register_out  in/out  5  destination register
- writeback_enabled_in / writeback_enabled_out  in/out  1  rd write intent
- writeback_data_out, writeback_data_valid_out  out  32, 1  value for rd
- misaligned_out  out  1  address misaligned for size; no bus access made
- access_illegal_out  out  1  illegal funct3 for load/store; no bus access made
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_write  out  1  1 = store
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_resp_valid  in  1  load data returned (one cycle)
- mem_rdata  in  32  returned word

## Operation
- States: EMPTY, REQ, WAIT, DONE.
- Accept: transfer_prev = prev_done && !stall_prev. Accept is allowed in EMPTY, or in DONE when transfer_next = done_next && !next_stall. Accepted fields are registered. Otherwise, EMPTY is entered when transfer_next fires.
- On accept, next state is:
  - DONE for a non-memory instruction, misaligned access, or illegal funct3.
  - REQ otherwise.
- REQ: mem_req_valid=1, held stable until mem_req_ready.
  - Store: handshake goes to DONE (posted write; no response expected).
  - Load: handshake goes to WAIT.
- WAIT: mem_resp_valid latches the extended data and goes to DONE. A response arriving in any other state is ignored.
- done_next = !rst && state==DONE. stall_prev = rst || (state!=EMPTY && !transfer_next).
- Sizes:
  - funct3 000 = B, 001 = H, 010 = W, 100 = BU (load only), 101 = HU (load only).
  - Any other value, or 100/101 on a store, sets access_illegal_out.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0.
- Store lanes:
  - SB: wstrb=4'b0001<<a[1:0], wdata={4{b}}.
  - SH: wstrb=4'b0011<<a[1:0], wdata={2{h}}.
  - SW: wstrb=4'hF.
- Load extract: byte/half selected by a[1:0], then sign- or zero-extended per funct3.
- writeback_data_out:
  - Load: extended data, valid=1.
  - Non-memory: result_data_in copy with its valid.
  - Store, misaligned, or illegal: valid=0.
- writeback_enabled_out is forced to 0 on misaligned or illegal.

## Timing
- Reset values: done_next=0, stall_prev=1, mem_req_valid=0, writeback_data_valid_out=0, misaligned_out=0, access_illegal_out=0, state=EMPTY.
- Reset mid-operation (REQ or WAIT) aborts to EMPTY. The bus is reset by the same rst.
- Non-memory instruction: done_next one cycle after accept.
- Store: earliest done_next 2 cycles after accept (REQ with ready=1).
- Load: earliest done_next 3 cycles after accept (REQ, then response on the first WAIT cycle).
- Back-to-back: in DONE with next_stall=0 and prev_done=1, a new instruction is accepted in the same cycle, giving no bubble.
- All outputs are registered state or combinational decode of registered state. There is no combinational path from mem_rdata to outputs.

## Structure
- cpu_pkg holds:
  - Funct3 constants: FUNCT3_B, FUNCT3_H, FUNCT3_W, FUNCT3_BU, FUNCT3_HU.
  - mem_stage_state_t enum {EMPTY, REQ, WAIT, DONE}.
- Sub-module load_store_align (combinational): from address low bits, funct3, store data and read word, produces wstrb, wdata, extended load data, misaligned and illegal flags.

## Test plan
- ADD result 0x0000_1234, next_stall=0 -> done_next one cycle after accept, writeback_data_out=0x0000_1234, no mem_req_valid.
- LB addr 0x103, mem_rdata 0x80FF_0000 -> mem_addr 0x100, writeback 0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr 0x102, data 0xABCD_1234 -> mem_wstrb 4'b1100, mem_wdata 0x1234_1234, mem_write=1, no writeback.
- LW addr 0x102 -> misaligned_out=1, no mem_req_valid, writeback_enabled_out=0.
- Load with mem_req_ready low 3 cycles and response 2 cycles later, next_stall high 2 cycles -> request stable, stall_prev high throughout, single done handshake.
- rst asserted in WAIT, response arrives after rst drops -> stays EMPTY, done_next=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, funct3 access-size codes and the memory-stage state type.
package cpu_pkg;
    localparam int ADDR_WIDTH              = 32;
    localparam int DATA_WIDTH              = 32;
    localparam int REGISTER_INDEXING_WIDTH = 5;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mem_stage_state_t;
endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for stores, load extraction/extension,
// and misalignment / illegal-size detection.
module load_store_align
    import cpu_pkg::*;
(
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [1:0]            addr_low,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] read_word,
    output logic [3:0]            wstrb,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misaligned,
    output logic                  illegal
);
    logic                  illegal_raw_s;
    logic                  misaligned_raw_s;
    logic                  mem_op_s;
    logic [DATA_WIDTH-1:0] shifted_s;

    assign mem_op_s  = is_load | is_store;
    assign shifted_s = read_word >> {addr_low, 3'b000};

    // Size legality and alignment; flags only meaningful for memory operations
    always_comb begin
        illegal_raw_s    = 1'b0;
        misaligned_raw_s = 1'b0;
        case (funct3)
            FUNCT3_B:  misaligned_raw_s = 1'b0;
            FUNCT3_H:  misaligned_raw_s = addr_low[0];
            FUNCT3_W:  misaligned_raw_s = (addr_low != 2'b00);
            FUNCT3_BU: illegal_raw_s    = is_store;
            FUNCT3_HU: begin
                illegal_raw_s    = is_store;
                misaligned_raw_s = addr_low[0];
            end
            default:   illegal_raw_s    = 1'b1;
        endcase
        illegal    = mem_op_s & illegal_raw_s;
        misaligned = mem_op_s & ~illegal_raw_s & misaligned_raw_s;
    end

    // Store lane placement
    always_comb begin
        wstrb = 4'b0000;
        wdata = {DATA_WIDTH{1'b0}};
        case (funct3)
            FUNCT3_B: begin
                wstrb = 4'b0001 << addr_low;
                wdata = {4{store_data[7:0]}};
            end
            FUNCT3_H: begin
                wstrb = 4'b0011 << addr_low;
                wdata = {2{store_data[15:0]}};
            end
            FUNCT3_W: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: begin
                wstrb = 4'b0000;
                wdata = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        load_data = {DATA_WIDTH{1'b0}};
        case (funct3)
            FUNCT3_B:  load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            FUNCT3_H:  load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            FUNCT3_W:  load_data = read_word;
            FUNCT3_BU: load_data = {24'd0, shifted_s[7:0]};
            FUNCT3_HU: load_data = {16'd0, shifted_s[15:0]};
            default:   load_data = {DATA_WIDTH{1'b0}};
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: single-outstanding data-bus access with the standard
// prev_done/stall_prev and done_next/next_stall stage handshake.
module memory_stage
    import cpu_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               prev_done,
    output logic                               stall_prev,
    input  logic                               next_stall,
    output logic                               done_next,
    input  logic [ADDR_WIDTH-1:0]              program_count_in,
    output logic [ADDR_WIDTH-1:0]              program_count_out,
    input  logic                               load_in,
    input  logic                               store_in,
    input  logic [2:0]                         funct_3_in,
    input  logic [DATA_WIDTH-1:0]              result_data_in,
    input  logic                               result_data_valid_in,
    input  logic [DATA_WIDTH-1:0]              memory_store_data_in,
    input  logic                               memory_store_data_valid_in,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
    output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
    input  logic                               writeback_enabled_in,
    output logic                               writeback_enabled_out,
    output logic [DATA_WIDTH-1:0]              writeback_data_out,
    output logic                               writeback_data_valid_out,
    output logic                               misaligned_out,
    output logic                               access_illegal_out,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic                               mem_write,
    output logic [3:0]                         mem_wstrb,
    output logic [DATA_WIDTH-1:0]              mem_wdata,
    input  logic                               mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]              mem_rdata
);
    mem_stage_state_t state_r, state_n_s;

    logic                  transfer_prev_s, transfer_next_s;
    logic                  is_load_in_s, is_store_in_s, mem_op_in_s;
    logic [1:0]            al_addr_low_s;
    logic [2:0]            al_funct3_s;
    logic [3:0]            al_wstrb_s;
    logic [DATA_WIDTH-1:0] al_wdata_s, al_load_data_s;
    logic                  al_misaligned_s, al_illegal_s;
    logic                  unused_s;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [2:0]            funct3_r;
    logic                  store_r;
    logic [3:0]            wstrb_r;
    logic [DATA_WIDTH-1:0] wdata_r;

    assign unused_s        = memory_store_data_valid_in;
    assign is_load_in_s    = load_in;
    assign is_store_in_s   = store_in & ~load_in;
    assign mem_op_in_s     = is_load_in_s | is_store_in_s;

    assign done_next       = ~rst & (state_r == DONE);
    assign transfer_next_s = done_next & ~next_stall;
    assign stall_prev      = rst | ((state_r != EMPTY) & ~transfer_next_s);
    assign transfer_prev_s = prev_done & ~stall_prev;

    assign mem_req_valid   = (state_r == REQ);
    assign mem_addr        = {addr_r[ADDR_WIDTH-1:2], 2'b00};
    assign mem_write       = store_r;
    assign mem_wstrb       = wstrb_r;
    assign mem_wdata       = wdata_r;

    // Decode the incoming instruction while accepting, otherwise the held one
    always_comb begin
        al_addr_low_s = addr_r[1:0];
        al_funct3_s   = funct3_r;
        if (transfer_prev_s) begin
            al_addr_low_s = result_data_in[1:0];
            al_funct3_s   = funct_3_in;
        end else begin
            al_addr_low_s = addr_r[1:0];
            al_funct3_s   = funct3_r;
        end
    end

    load_store_align u_align (
        .is_load    (is_load_in_s),
        .is_store   (is_store_in_s),
        .addr_low   (al_addr_low_s),
        .funct3     (al_funct3_s),
        .store_data (memory_store_data_in),
        .read_word  (mem_rdata),
        .wstrb      (al_wstrb_s),
        .wdata      (al_wdata_s),
        .load_data  (al_load_data_s),
        .misaligned (al_misaligned_s),
        .illegal    (al_illegal_s)
    );

    // Stage state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_n_s = state_r;
        if (transfer_prev_s) begin
            if (!mem_op_in_s || al_misaligned_s || al_illegal_s) begin
                state_n_s = DONE;
            end else begin
                state_n_s = REQ;
            end
        end else begin
            case (state_r)
                EMPTY: state_n_s = EMPTY;
                REQ: begin
                    if (mem_req_ready) begin
                        state_n_s = store_r ? DONE : WAIT;
                    end else begin
                        state_n_s = REQ;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state_n_s = DONE;
                    end else begin
                        state_n_s = WAIT;
                    end
                end
                DONE: begin
                    if (transfer_next_s) begin
                        state_n_s = EMPTY;
                    end else begin
                        state_n_s = DONE;
                    end
                end
                default: state_n_s = EMPTY;
            endcase
        end
    end

    // Capture accepted instruction fields; latch load data on the response
    always_ff @(posedge clk) begin
        if (rst) begin
            program_count_out        <= {ADDR_WIDTH{1'b0}};
            write_register_out       <= {REGISTER_INDEXING_WIDTH{1'b0}};
            writeback_enabled_out    <= 1'b0;
            writeback_data_out       <= {DATA_WIDTH{1'b0}};
            writeback_data_valid_out <= 1'b0;
            misaligned_out           <= 1'b0;
            access_illegal_out       <= 1'b0;
            addr_r                   <= {ADDR_WIDTH{1'b0}};
            funct3_r                 <= 3'b000;
            store_r                  <= 1'b0;
            wstrb_r                  <= 4'b0000;
            wdata_r                  <= {DATA_WIDTH{1'b0}};
        end else if (transfer_prev_s) begin
            program_count_out        <= program_count_in;
            write_register_out       <= write_register_in;
            writeback_enabled_out    <= writeback_enabled_in & ~al_misaligned_s & ~al_illegal_s;
            writeback_data_out       <= mem_op_in_s ? {DATA_WIDTH{1'b0}} : result_data_in;
            writeback_data_valid_out <= mem_op_in_s ? 1'b0 : result_data_valid_in;
            misaligned_out           <= al_misaligned_s;
            access_illegal_out       <= al_illegal_s;
            addr_r                   <= result_data_in[ADDR_WIDTH-1:0];
            funct3_r                 <= funct_3_in;
            store_r                  <= is_store_in_s;
            wstrb_r                  <= al_wstrb_s;
            wdata_r                  <= al_wdata_s;
        end else if ((state_r == WAIT) && mem_resp_valid) begin
            writeback_data_out       <= al_load_data_s;
            writeback_data_valid_out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage against an arithmetic model
// of the load/store rules.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        prev_done, stall_prev, next_stall, done_next;
    logic [31:0] program_count_in, program_count_out;
    logic        load_in, store_in;
    logic [2:0]  funct_3_in;
    logic [31:0] result_data_in;
    logic        result_data_valid_in;
    logic [31:0] memory_store_data_in;
    logic        memory_store_data_valid_in;
    logic [4:0]  write_register_in, write_register_out;
    logic        writeback_enabled_in, writeback_enabled_out;
    logic [31:0] writeback_data_out;
    logic        writeback_data_valid_out, misaligned_out, access_illegal_out;
    logic        mem_req_valid, mem_req_ready, mem_write, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst(rst), .prev_done(prev_done), .stall_prev(stall_prev),
        .next_stall(next_stall), .done_next(done_next),
        .program_count_in(program_count_in), .program_count_out(program_count_out),
        .load_in(load_in), .store_in(store_in), .funct_3_in(funct_3_in),
        .result_data_in(result_data_in), .result_data_valid_in(result_data_valid_in),
        .memory_store_data_in(memory_store_data_in),
        .memory_store_data_valid_in(memory_store_data_valid_in),
        .write_register_in(write_register_in), .write_register_out(write_register_out),
        .writeback_enabled_in(writeback_enabled_in), .writeback_enabled_out(writeback_enabled_out),
        .writeback_data_out(writeback_data_out), .writeback_data_valid_out(writeback_data_valid_out),
        .misaligned_out(misaligned_out), .access_illegal_out(access_illegal_out),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    // op: 0 = non-memory, 1 = load, 2 = store
    function automatic logic exp_ill(input int op, input logic [2:0] f3);
        if (op == 0) return 1'b0;
        if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) return 1'b0;
        if ((f3 == 3'd4 || f3 == 3'd5) && op == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_mis(input int op, input logic [2:0] f3, input logic [31:0] a);
        if (op == 0 || exp_ill(op, f3)) return 1'b0;
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [2:0] f3, input logic [1:0] a);
        logic [63:0] v;
        int n;
        n = nbytes(f3);
        if (n == 4) return rd;
        v = {32'd0, rd} >> (8 * a);
        v = v & ((64'd1 << (8 * n)) - 64'd1);
        if (f3 < 3'd4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_wstrb(input logic [2:0] f3, input logic [1:0] a);
        int m;
        m = ((1 << nbytes(f3)) - 1) << a;
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] s);
        case (nbytes(f3))
            1:       return {24'd0, s[7:0]} * 32'h0101_0101;
            2:       return {16'd0, s[15:0]} * 32'h0001_0001;
            default: return s;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int op, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata);
        load_in              = (op == 1);
        store_in             = (op == 2);
        funct_3_in           = f3;
        result_data_in       = addr;
        memory_store_data_in = sdata;
        memory_store_data_valid_in = (op == 2);
        program_count_in     = $urandom;
        write_register_in    = 5'($urandom_range(0, 31));
        writeback_enabled_in = (op != 2);
    endtask

    // One full instruction through the stage with a scripted bus and consumer
    task automatic run_op(input string name, input int op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                          input logic rv, input int rdly, input int resp_dly, input int stall_cyc);
        logic        ill, mis, legal_mem, exp_valid, exp_wben;
        logic [31:0] exp_data, exp_pc, held;
        logic [4:0]  exp_rd;
        int          t;
        ill       = exp_ill(op, f3);
        mis       = exp_mis(op, f3, addr);
        legal_mem = (op != 0) && !ill && !mis;
        @(negedge clk);
        drive(op, f3, addr, sdata);
        result_data_valid_in = rv;
        exp_pc   = program_count_in;
        exp_rd   = write_register_in;
        exp_wben = writeback_enabled_in && !ill && !mis;
        prev_done  = 1'b1;
        next_stall = (stall_cyc > 0);
        t = 0;
        while (stall_prev && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (stall_prev !== 1'b0) begin
            $display("FAIL %s accept_timeout stall_prev=%b required 0", name, stall_prev);
            errors++;
            prev_done = 1'b0;
            return;
        end
        @(negedge clk);
        prev_done = 1'b0;
        if (legal_mem) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_addr !== {addr[31:2], 2'b00} || mem_write !== (op == 2)) begin
                $display("FAIL %s req got valid=%b addr=%h write=%b required 1 %h %b",
                         name, mem_req_valid, mem_addr, mem_write, {addr[31:2], 2'b00}, op == 2);
                errors++;
            end
            if (op == 2) begin
                checks++;
                if (mem_wstrb !== exp_wstrb(f3, addr[1:0]) || mem_wdata !== exp_wdata(f3, sdata)) begin
                    $display("FAIL %s lanes got wstrb=%b wdata=%h required %b %h", name,
                             mem_wstrb, mem_wdata, exp_wstrb(f3, addr[1:0]), exp_wdata(f3, sdata));
                    errors++;
                end
            end
            for (int i = 0; i < rdly; i++) begin
                @(negedge clk);
                checks++;
                if (mem_req_valid !== 1'b1 || mem_addr !== {addr[31:2], 2'b00} || stall_prev !== 1'b1 || done_next !== 1'b0) begin
                    $display("FAIL %s req_hold got valid=%b addr=%h stall=%b done=%b required 1 %h 1 0",
                             name, mem_req_valid, mem_addr, stall_prev, done_next, {addr[31:2], 2'b00});
                    errors++;
                end
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            if (op == 1) begin
                for (int i = 0; i < resp_dly; i++) begin
                    checks++;
                    if (mem_req_valid !== 1'b0 || done_next !== 1'b0 || stall_prev !== 1'b1) begin
                        $display("FAIL %s wait got valid=%b done=%b stall=%b required 0 0 1",
                                 name, mem_req_valid, done_next, stall_prev);
                        errors++;
                    end
                    @(negedge clk);
                end
                mem_resp_valid = 1'b1;
                mem_rdata      = rdata;
                @(negedge clk);
                mem_resp_valid = 1'b0;
                mem_rdata      = $urandom;
            end
        end
        exp_valid = (op == 0) ? rv : legal_mem && (op == 1);
        exp_data  = (op == 0) ? addr : exp_load(rdata, f3, addr[1:0]);
        checks++;
        if (done_next !== 1'b1 || mem_req_valid !== 1'b0) begin
            $display("FAIL %s done got done=%b req=%b required 1 0", name, done_next, mem_req_valid);
            errors++;
        end
        checks++;
        if (writeback_data_valid_out !== exp_valid || (exp_valid && writeback_data_out !== exp_data)) begin
            $display("FAIL %s writeback got valid=%b data=%h required %b %h",
                     name, writeback_data_valid_out, writeback_data_out, exp_valid, exp_data);
            errors++;
        end
        checks++;
        if (misaligned_out !== mis || access_illegal_out !== ill || writeback_enabled_out !== exp_wben ||
            program_count_out !== exp_pc || write_register_out !== exp_rd) begin
            $display("FAIL %s flags got mis=%b ill=%b wben=%b pc=%h rd=%0d required %b %b %b %h %0d",
                     name, misaligned_out, access_illegal_out, writeback_enabled_out, program_count_out,
                     write_register_out, mis, ill, exp_wben, exp_pc, exp_rd);
            errors++;
        end
        held = writeback_data_out;
        for (int i = 0; i < stall_cyc; i++) begin
            @(negedge clk);
            checks++;
            if (done_next !== 1'b1 || stall_prev !== 1'b1 || writeback_data_out !== held) begin
                $display("FAIL %s hold got done=%b stall=%b data=%h required 1 1 %h",
                         name, done_next, stall_prev, writeback_data_out, held);
                errors++;
            end
        end
        next_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (done_next !== 1'b0 || stall_prev !== 1'b0) begin
            $display("FAIL %s release got done=%b stall=%b required 0 0", name, done_next, stall_prev);
            errors++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_next !== 1'b0 || stall_prev !== 1'b1 || mem_req_valid !== 1'b0 ||
            writeback_data_valid_out !== 1'b0 || misaligned_out !== 1'b0 || access_illegal_out !== 1'b0) begin
            $display("FAIL reset got done=%b stall=%b req=%b wbv=%b mis=%b ill=%b required 0 1 0 0 0 0",
                     done_next, stall_prev, mem_req_valid, writeback_data_valid_out, misaligned_out, access_illegal_out);
            errors++;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_prev !== 1'b0 || done_next !== 1'b0) begin
            $display("FAIL reset_release got stall=%b done=%b required 0 0", stall_prev, done_next);
            errors++;
        end
    endtask

    task automatic test_directed();
        run_op("add",      0, 3'd0, 32'h0000_1234, 32'h0,          32'h0,          1'b1, 0, 0, 0);
        run_op("lb",       1, 3'd0, 32'h0000_0103, 32'h0,          32'h80FF_0000, 1'b0, 0, 0, 0);
        run_op("lbu",      1, 3'd4, 32'h0000_0103, 32'h0,          32'h80FF_0000, 1'b0, 0, 0, 0);
        run_op("sh",       2, 3'd1, 32'h0000_0102, 32'hABCD_1234, 32'h0,          1'b0, 0, 0, 0);
        run_op("lw_mis",   1, 3'd2, 32'h0000_0102, 32'h0,          32'h0,          1'b0, 0, 0, 0);
        run_op("sbu_ill",  2, 3'd4, 32'h0000_0100, 32'h0,          32'h0,          1'b0, 0, 0, 0);
        run_op("lh_stall", 1, 3'd1, 32'h0000_0202, 32'h0,          32'h8001_7F00, 1'b0, 3, 2, 2);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(0, 3'd0, 32'h0000_00AA, 32'h0);
        result_data_valid_in = 1'b1;
        prev_done = 1'b1;
        @(negedge clk);
        checks++;
        if (done_next !== 1'b1 || stall_prev !== 1'b0 || writeback_data_out !== 32'h0000_00AA) begin
            $display("FAIL b2b_first got done=%b stall=%b data=%h required 1 0 000000aa",
                     done_next, stall_prev, writeback_data_out);
            errors++;
        end
        drive(0, 3'd0, 32'h0000_00BB, 32'h0);
        @(negedge clk);
        prev_done = 1'b0;
        checks++;
        if (done_next !== 1'b1 || writeback_data_out !== 32'h0000_00BB) begin
            $display("FAIL b2b_second got done=%b data=%h required 1 000000bb", done_next, writeback_data_out);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (done_next !== 1'b0) begin
            $display("FAIL b2b_drain got done=%b required 0", done_next);
            errors++;
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        drive(1, 3'd2, 32'h0000_0200, 32'h0);
        prev_done = 1'b1;
        @(negedge clk);
        prev_done     = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (done_next !== 1'b0 || stall_prev !== 1'b1 || mem_req_valid !== 1'b0) begin
            $display("FAIL rst_wait got done=%b stall=%b req=%b required 0 1 0", done_next, stall_prev, mem_req_valid);
            errors++;
        end
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done_next !== 1'b0 || stall_prev !== 1'b0 || writeback_data_valid_out !== 1'b0) begin
            $display("FAIL rst_late_resp got done=%b stall=%b wbv=%b required 0 0 0",
                     done_next, stall_prev, writeback_data_valid_out);
            errors++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            int          op;
            logic [2:0]  f3;
            op = $urandom_range(0, 2);
            f3 = 3'($urandom_range(0, 7));
            run_op("rand", op, f3, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
        end
    endtask

    initial begin
        rst = 1'b1;
        prev_done = 1'b0;
        next_stall = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata = 32'h0;
        drive(0, 3'd0, 32'h0, 32'h0);
        result_data_valid_in = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
